// File: rtl/matrix_bank_loader.sv
// Streams value1/value2 word pairs into NUM_MAT dual-port matrix RAMs, filling banks in order.
// Optional running checksum of accepted beats is built when LOADER_CHECKSUM_EN is defined.
module matrix_bank_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 14,
  parameter int NUM_MAT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_MAT*(ADDR_W-1)-1:0] len_pairs,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             value1,
  input  logic [DATA_W-1:0]             value2,
  output logic [ADDR_W-1:0]             addr_a,
  output logic [ADDR_W-1:0]             addr_b,
  output logic [DATA_W-1:0]             din_a,
  output logic [DATA_W-1:0]             din_b,
  output logic [NUM_MAT-1:0]            en,
  output logic [NUM_MAT-1:0]            we_a,
  output logic [NUM_MAT-1:0]            we_b,
  output logic [2:0]                    bank_idx,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_W-1:0]             checksum
);

  localparam int LW = ADDR_W - 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state;
  logic [NUM_MAT*LW-1:0] lens_q;
  logic [LW-1:0]       k;
  logic [LW-1:0]       cur_len;
  logic [NUM_MAT-1:0]  bank_onehot;
  logic                accept;
  logic [3:0]          start_bank;
  logic [3:0]          next_bank;

  // Lowest-numbered bank at or above 'from' with a nonzero length, as {found, index}.
  function automatic logic [3:0] find_bank(input logic [NUM_MAT*LW-1:0] l, input int from);
    find_bank = '0;
    for (int i = NUM_MAT - 1; i >= 0; i--) begin
      if (i >= from && l[i*LW +: LW] != '0) begin
        find_bank = {1'b1, 3'(i)};
      end
    end
  endfunction

  assign busy        = (state == LOAD);
  assign in_ready    = busy;
  assign accept      = in_valid & busy;
  assign bank_onehot = NUM_MAT'(1) << bank_idx;
  assign start_bank  = find_bank(len_pairs, 0);
  assign next_bank   = find_bank(lens_q, int'(bank_idx) + 1);

  always_comb begin
    cur_len = '0;
    for (int i = 0; i < NUM_MAT; i++) begin
      if (bank_idx == 3'(i)) begin
        cur_len = lens_q[i*LW +: LW];
      end
    end
  end

  // Zero-length banks are skipped when choosing the next bank, so the last beat of one
  // bank and the first beat of the next land on consecutive edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lens_q   <= '0;
      k        <= '0;
      bank_idx <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      din_a    <= '0;
      din_b    <= '0;
      en       <= '0;
      we_a     <= '0;
      we_b     <= '0;
      done     <= 1'b0;
    end else begin
      en   <= '0;
      we_a <= '0;
      we_b <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lens_q   <= len_pairs;
            k        <= '0;
            done     <= 1'b0;
            bank_idx <= start_bank[2:0];
            state    <= start_bank[3] ? LOAD : DONE;
          end else if (state == DONE) begin
            done <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            en     <= bank_onehot;
            we_a   <= bank_onehot;
            we_b   <= bank_onehot;
            addr_a <= {k, 1'b0};
            addr_b <= {k, 1'b1};
            din_a  <= value1;
            din_b  <= value2;
            if (k == cur_len - LW'(1)) begin
              k <= '0;
              if (next_bank[3]) begin
                bank_idx <= next_bank[2:0];
              end else begin
                state <= DONE;
              end
            end else begin
              k <= k + LW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (start && state != LOAD) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + value1 + value2;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_bank_loader.sv
// Self-checking bench for matrix_bank_loader: randomized loads compared against a bank/pair write list
// built from the lengths alone. Honours LOADER_CHECKSUM_EN for the expected checksum.
module tb_matrix_bank_loader;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 14;
  localparam int NUM_MAT = 3;
  localparam int LW      = ADDR_W - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [NUM_MAT*LW-1:0] len_pairs;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     value1;
  logic [DATA_W-1:0]     value2;
  logic [ADDR_W-1:0]     addr_a;
  logic [ADDR_W-1:0]     addr_b;
  logic [DATA_W-1:0]     din_a;
  logic [DATA_W-1:0]     din_b;
  logic [NUM_MAT-1:0]    en;
  logic [NUM_MAT-1:0]    we_a;
  logic [NUM_MAT-1:0]    we_b;
  logic [2:0]            bank_idx;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     checksum;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  en;
    logic [2:0]  we_a;
    logic [2:0]  we_b;
    logic [13:0] addr_a;
    logic [13:0] addr_b;
    logic [31:0] din_a;
    logic [31:0] din_b;
  } wr_t;

  typedef struct {
    logic [2:0]  bank;
    int          pair;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  always #5 clk = ~clk;

  matrix_bank_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_MAT(NUM_MAT)) dut (
    .clk(clk), .reset(reset), .start(start), .len_pairs(len_pairs),
    .in_valid(in_valid), .in_ready(in_ready), .value1(value1), .value2(value2),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .en(en), .we_a(we_a), .we_b(we_b), .bank_idx(bank_idx),
    .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full load: start pulse, beats with random in_valid gaps, then compare the observed
  // write strobes with the write list implied by bank order and per-bank lengths.
  task automatic applyStimulus(input int l0, input int l1, input int l2, input int gap_pct,
                               input bit seq_vals, input string name);
    int          lens[3];
    logic [31:0] v1[$];
    logic [31:0] v2[$];
    exp_t        exp_q[$];
    wr_t         obs_q[$];
    int          total, ptr, j, start_cyc, last_acc_cyc, done_cyc, busy_cnt, bad_bank, n_cmp;
    logic [31:0] sum, exp_ck;
    bit          acc;
    lens = '{l0, l1, l2};
    total = l0 + l1 + l2;
    sum = '0;
    for (int i = 0; i < total; i++) begin
      if (seq_vals) begin
        v1.push_back(32'(i + 1));
        v2.push_back(32'(2 * (i + 1)));
      end else begin
        v1.push_back($urandom);
        v2.push_back($urandom);
      end
      sum = sum + v1[i] + v2[i];
    end
    j = 0;
    for (int b = 0; b < 3; b++) begin
      for (int p = 0; p < lens[b]; p++) begin
        exp_q.push_back('{3'(b), p, v1[j], v2[j]});
        j++;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = '0;
`endif

    start = 1'b1;
    len_pairs = {LW'(l2), LW'(l1), LW'(l0)};
    in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    len_pairs = {LW'($urandom), LW'($urandom), LW'($urandom)};

    ptr = 0;
    done_cyc = -1;
    last_acc_cyc = start_cyc;
    busy_cnt = 0;
    bad_bank = 0;
    for (int n = 0; n < 400 && done_cyc < 0; n++) begin
      if (en != 0 || we_a != 0 || we_b != 0)
        obs_q.push_back('{cyc, en, we_a, we_b, addr_a, addr_b, din_a, din_b});
      if (busy) begin
        busy_cnt++;
        if (bank_idx > 3'd2) bad_bank++;
        else if (lens[bank_idx] == 0) bad_bank++;
      end
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (ptr < total) begin
          in_valid = (int'($urandom_range(99)) >= gap_pct);
          value1 = v1[ptr];
          value2 = v2[ptr];
        end else begin
          in_valid = ($urandom_range(1) == 1);
          value1 = $urandom;
          value2 = $urandom;
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        cyc++;
        if (acc) begin
          ptr++;
          last_acc_cyc = cyc;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;

    checkOutput({name, " done_seen"}, 64'(done_cyc >= 0), 64'(1));
    checkOutput({name, " done_latency"}, 64'(done_cyc - last_acc_cyc), 64'(1));
    checkOutput({name, " beats_accepted"}, 64'(ptr), 64'(total));
    checkOutput({name, " strobe_count"}, 64'(obs_q.size()), 64'(total));
    n_cmp = (obs_q.size() < total) ? obs_q.size() : total;
    for (int i = 0; i < n_cmp; i++) begin
      checkOutput($sformatf("%s strobe%0d_ctrl", name, i),
                  64'({obs_q[i].en, obs_q[i].we_a, obs_q[i].we_b, obs_q[i].addr_a, obs_q[i].addr_b}),
                  64'({3'(1) << exp_q[i].bank, 3'(1) << exp_q[i].bank, 3'(1) << exp_q[i].bank,
                       14'(2 * exp_q[i].pair), 14'(2 * exp_q[i].pair + 1)}));
      checkOutput($sformatf("%s strobe%0d_data", name, i),
                  {obs_q[i].din_a, obs_q[i].din_b}, {exp_q[i].d1, exp_q[i].d2});
    end
    if (gap_pct == 0 && n_cmp > 0) begin
      checkOutput({name, " first_strobe_cycle"}, 64'(obs_q[0].cyc - start_cyc), 64'(1));
      checkOutput({name, " strobes_contiguous"}, 64'(obs_q[n_cmp-1].cyc - obs_q[0].cyc), 64'(n_cmp - 1));
    end
    checkOutput({name, " bank_idx_valid_while_busy"}, 64'(bad_bank), 64'(0));
    if (total == 0) checkOutput({name, " busy_never_high"}, 64'(busy_cnt), 64'(0));
    checkOutput({name, " checksum"}, 64'(checksum), 64'(exp_ck));

    repeat (2) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checkOutput({name, " done_held"}, 64'({done, busy, en}), 64'({1'b1, 1'b0, 3'b000}));
  endtask

  // Pushes n beats with in_valid held high; returns how many were accepted within the bound.
  task automatic feedBeats(input int n, output int got);
    bit acc;
    got = 0;
    for (int c = 0; c < 4 * n + 10 && got < n; c++) begin
      in_valid = 1'b1;
      value1 = $urandom;
      value2 = $urandom;
      acc = in_ready;
      @(posedge clk);
      cyc++;
      if (acc) got++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int got;
    reset = 1'b1;
    start = 1'b0;
    len_pairs = '0;
    in_valid = 1'b0;
    value1 = '0;
    value2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ctrl", 64'({in_ready, busy, done, bank_idx, en, we_a, we_b}), 64'(0));
    checkOutput("reset addr", 64'({addr_a, addr_b, din_a}), 64'(0));
    checkOutput("reset data", {din_b, checksum}, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(2, 3, 1, 0, 1'b1, "lens231");
    applyStimulus(0, 4, 0, 0, 1'b0, "lens040");
    applyStimulus(0, 0, 0, 0, 1'b0, "lens000");
    applyStimulus(5, 5, 5, 40, 1'b0, "lens555_gaps");

    // Abort mid-bank1, with an ignored start pulse along the way.
    start = 1'b1;
    len_pairs = {LW'(2), LW'(4), LW'(3)};
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start = 1'b0;
    feedBeats(2, got);
    checkOutput("abort first_beats", 64'(got), 64'(2));
    start = 1'b1;
    len_pairs = {LW'(0), LW'(5), LW'(0)};
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_ignored busy_bank", 64'({busy, done, bank_idx}), 64'({1'b1, 1'b0, 3'd0}));
    feedBeats(2, got);
    checkOutput("abort bank1_beats", 64'(got), 64'(2));
    checkOutput("bank1 first_write", 64'({en, we_a, addr_a, addr_b, bank_idx}),
                64'({3'b010, 3'b010, 14'd0, 14'd1, 3'd1}));
    reset = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput("midreset ctrl", 64'({in_ready, busy, done, bank_idx, en, we_a, we_b}), 64'(0));
    checkOutput("midreset addr", 64'({addr_a, addr_b, din_a}), 64'(0));
    checkOutput("midreset data", {din_b, checksum}, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(1, 2, 2, 25, 1'b0, "after_reset");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(int'($urandom_range(4)), int'($urandom_range(4)), int'($urandom_range(4)),
                    30, 1'b0, $sformatf("random%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
